// File: rtl/data_bus_lsu.sv
// Load/store unit for the MEM stage: one outstanding transfer on a simple request/ack data bus.
// Big-endian lane mapping. Loads are latched on ack and presented to MEM/WB in DONE.
module data_bus_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic        stall_hold,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        misalign
);
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg;
    logic [1:0]  addr_lo_reg;
    logic [1:0]  size_reg;
    logic        sign_reg;
    logic        is_load_reg;
    logic [31:0] load_val_reg;

    logic        is_mem, is_load, is_signed, misaligned_op;
    logic [1:0]  size;
    logic [3:0]  sel_next;
    logic [31:0] wdata_next;
    logic [31:0] load_val_next;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // size: 0 = byte, 1 = half, 2 = word
    always_comb begin
        is_mem    = 1'b1;
        is_load   = 1'b0;
        is_signed = 1'b0;
        size      = 2'd0;
        case (mem_aluop)
            OP_LB:  begin is_load = 1'b1; is_signed = 1'b1; size = 2'd0; end
            OP_LBU: begin is_load = 1'b1; size = 2'd0; end
            OP_LH:  begin is_load = 1'b1; is_signed = 1'b1; size = 2'd1; end
            OP_LHU: begin is_load = 1'b1; size = 2'd1; end
            OP_LW:  begin is_load = 1'b1; size = 2'd2; end
            OP_SB:  size = 2'd0;
            OP_SH:  size = 2'd1;
            OP_SW:  size = 2'd2;
            default: is_mem = 1'b0;
        endcase
    end

    assign misaligned_op = is_mem && (((size == 2'd1) && mem_mem_addr[0]) ||
                                      ((size == 2'd2) && (mem_mem_addr[1:0] != 2'b00)));

    always_comb begin
        sel_next   = 4'b1111;
        wdata_next = 32'd0;
        case (size)
            2'd0:    sel_next = 4'b1000 >> mem_mem_addr[1:0];
            2'd1:    sel_next = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
            default: sel_next = 4'b1111;
        endcase
        if (!is_load) begin
            case (size)
                2'd0:    wdata_next = {4{mem_reg2[7:0]}};
                2'd1:    wdata_next = {2{mem_reg2[15:0]}};
                default: wdata_next = mem_reg2;
            endcase
        end
    end

    // Lane extraction uses the offset captured at request time, not the live address.
    always_comb begin
        case (addr_lo_reg)
            2'd0:    rd_byte = bus_rdata[31:24];
            2'd1:    rd_byte = bus_rdata[23:16];
            2'd2:    rd_byte = bus_rdata[15:8];
            default: rd_byte = bus_rdata[7:0];
        endcase
        rd_half = addr_lo_reg[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        case (size_reg)
            2'd0:    load_val_next = {{24{sign_reg & rd_byte[7]}}, rd_byte};
            2'd1:    load_val_next = {{16{sign_reg & rd_half[15]}}, rd_half};
            default: load_val_next = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'd0;
            bus_sel      <= 4'd0;
            bus_wdata    <= 32'd0;
            load_val_reg <= 32'd0;
            addr_lo_reg  <= 2'd0;
            size_reg     <= 2'd0;
            sign_reg     <= 1'b0;
            is_load_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (is_mem && !misaligned_op) begin
                        state_reg   <= BUSY;
                        bus_req     <= 1'b1;
                        bus_we      <= !is_load;
                        bus_addr    <= {mem_mem_addr[31:2], 2'b00};
                        bus_sel     <= sel_next;
                        bus_wdata   <= wdata_next;
                        addr_lo_reg <= mem_mem_addr[1:0];
                        size_reg    <= size;
                        sign_reg    <= is_signed;
                        is_load_reg <= is_load;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        state_reg    <= DONE;
                        bus_req      <= 1'b0;
                        load_val_reg <= load_val_next;
                    end
                end
                DONE: begin
                    if (!stall_hold) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq = 1'b0;
        misalign = 1'b0;
        wb_wd    = mem_wd;
        wb_wreg  = 1'b0;
        wb_wdata = 32'd0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (!is_mem) begin
                        wb_wreg  = mem_wreg;
                        wb_wdata = mem_wdata;
                    end else if (misaligned_op) begin
                        misalign = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                    end
                end
                BUSY: stallreq = 1'b1;
                DONE: begin
                    if (is_load_reg) begin
                        wb_wreg  = 1'b1;
                        wb_wdata = load_val_reg;
                    end
                end
                default: stallreq = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus_lsu.sv
// Bench for data_bus_lsu: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed bus and writeback values.
module tb_data_bus_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_reg2, mem_wdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg, stall_hold;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;
    logic [4:0]  wb_wd;
    logic        wb_wreg, stallreq, misalign;
    logic [31:0] wb_wdata;

    int tests = 0;
    int fails = 0;

    data_bus_lsu dut (
        .clk(clk), .rst(rst), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
        .mem_reg2(mem_reg2), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .stall_hold(stall_hold), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .stallreq(stallreq),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [7:0] op);
        case (op)
            8'hE0, 8'hE4, 8'hE8: return 1;
            8'hE1, 8'hE5, 8'hE9: return 2;
            8'hE3, 8'hEB:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_load(input logic [7:0] op);
        return (op == 8'hE0) || (op == 8'hE4) || (op == 8'hE1) || (op == 8'hE5) || (op == 8'hE3);
    endfunction

    // phase: 0 = no transfer, 1 = on the bus, 2 = result presented
    int          m_phase = 0;
    bit          m_started = 0;
    bit          m_req, m_we, m_load, m_sgn;
    int          m_off, m_size;
    logic [31:0] m_addr, m_bwdata, m_val;
    logic [3:0]  m_sel;

    always @(posedge clk) begin
        int s;
        longint unsigned mask, v;
        if (rst) begin
            m_started = 1;
            m_phase = 0; m_req = 0; m_we = 0; m_addr = 0; m_sel = 0; m_bwdata = 0; m_val = 0;
            m_load = 0;
        end else if (m_phase == 0) begin
            s = op_size(mem_aluop);
            if (s != 0 && (mem_mem_addr % s) == 0) begin
                m_phase = 1;
                m_req   = 1;
                m_load  = op_load(mem_aluop);
                m_sgn   = (mem_aluop == 8'hE0) || (mem_aluop == 8'hE1);
                m_we    = !m_load;
                m_size  = s;
                m_off   = int'(mem_mem_addr % 4);
                m_addr  = mem_mem_addr - 32'(m_off);
                m_sel   = 4'(((1 << s) - 1) << (4 - m_off - s));
                mask    = (64'd1 << (8 * s)) - 1;
                v       = 0;
                if (!m_load)
                    for (int k = 0; k < 4 / s; k++) v = v | ((longint'(mem_reg2) & mask) << (8 * s * k));
                m_bwdata = 32'(v);
            end
        end else if (m_phase == 1) begin
            if (bus_ack) begin
                mask = (64'd1 << (8 * m_size)) - 1;
                v = (longint'(bus_rdata) >> (8 * (4 - m_off - m_size))) & mask;
                if (m_sgn && v[8 * m_size - 1]) v = v | ~mask;
                m_val   = 32'(v);
                m_req   = 0;
                m_phase = 2;
            end
        end else if (!stall_hold) begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        int s;
        bit mis;
        if (m_started) begin
            chk("bus_req", 32'(bus_req), 32'(m_req));
            chk("bus_we", 32'(bus_we), 32'(m_we));
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_sel", 32'(bus_sel), 32'(m_sel));
            chk("bus_wdata", bus_wdata, m_bwdata);
            chk("wb_wd", 32'(wb_wd), 32'(mem_wd));
            s = op_size(mem_aluop);
            mis = (s != 0) && ((mem_mem_addr % s) != 0);
            if (rst) begin
                chk("rst_stallreq", 32'(stallreq), 0);
                chk("rst_wb_wreg", 32'(wb_wreg), 0);
                chk("rst_misalign", 32'(misalign), 0);
            end else if (m_phase == 0) begin
                chk("idle_stallreq", 32'(stallreq), 32'(s != 0 && !mis));
                chk("idle_misalign", 32'(misalign), 32'(mis));
                chk("idle_wb_wreg", 32'(wb_wreg), (s == 0) ? 32'(mem_wreg) : 0);
                chk("idle_wb_wdata", wb_wdata, (s == 0) ? mem_wdata : 0);
            end else if (m_phase == 1) begin
                chk("busy_stallreq", 32'(stallreq), 1);
                chk("busy_misalign", 32'(misalign), 0);
                chk("busy_wb_wreg", 32'(wb_wreg), 0);
            end else begin
                chk("done_stallreq", 32'(stallreq), 0);
                chk("done_misalign", 32'(misalign), 0);
                chk("done_wb_wreg", 32'(wb_wreg), 32'(m_load));
                chk("done_wb_wdata", wb_wdata, m_load ? m_val : 0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic nop_op();
        mem_aluop = 8'h25; mem_mem_addr = 32'd0; mem_reg2 = 32'd0;
        mem_wd = 5'd1; mem_wreg = 1'b0; mem_wdata = 32'd0;
    endtask

    task automatic run_txn(input string name, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] reg2, input logic [31:0] rdata, input int ack_delay,
                           input int hold, input logic [3:0] exp_sel, input logic exp_we,
                           input logic [31:0] exp_bwdata, input logic exp_wreg,
                           input logic [31:0] exp_wbdata);
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
        mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h0BAD0BAD;
        @(negedge clk); chk({name, " stallreq_idle"}, 32'(stallreq), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, " bus_req"}, 32'(bus_req), 1);
        chk({name, " bus_addr"}, bus_addr, {addr[31:2], 2'b00});
        chk({name, " bus_sel"}, 32'(bus_sel), 32'(exp_sel));
        chk({name, " bus_we"}, 32'(bus_we), 32'(exp_we));
        chk({name, " bus_wdata"}, bus_wdata, exp_bwdata);
        for (int i = 1; i < ack_delay; i++) begin @(posedge clk); #1; end
        bus_ack = 1'b1; bus_rdata = rdata; stall_hold = (hold > 0);
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = 32'h5A5A5A5A;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, " held_wb_wdata"}, wb_wdata, exp_wbdata);
            chk({name, " held_wb_wreg"}, 32'(wb_wreg), 32'(exp_wreg));
            @(posedge clk); #1;
        end
        stall_hold = 1'b0;
        @(negedge clk);
        chk({name, " wb_wdata"}, wb_wdata, exp_wbdata);
        chk({name, " wb_wreg"}, 32'(wb_wreg), 32'(exp_wreg));
        chk({name, " stallreq_done"}, 32'(stallreq), 0);
        chk({name, " bus_req_done"}, 32'(bus_req), 0);
        $display("[TB] txn %s op=%h addr=%h sel=%b wb_wdata=%h wb_wreg=%0b",
                 name, op, addr, bus_sel, wb_wdata, wb_wreg);
        @(posedge clk); #1;
        nop_op();
    endtask

    task automatic run_misaligned(input string name, input logic [7:0] op, input logic [31:0] addr);
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = 32'hFFFFFFFF;
        mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'h77;
        @(negedge clk);
        chk({name, " misalign"}, 32'(misalign), 1);
        chk({name, " stallreq"}, 32'(stallreq), 0);
        chk({name, " wb_wreg"}, 32'(wb_wreg), 0);
        chk({name, " wb_wdata"}, wb_wdata, 0);
        @(posedge clk); #1;
        nop_op();
        @(negedge clk);
        chk({name, " misalign_after"}, 32'(misalign), 0);
        chk({name, " bus_req_after"}, 32'(bus_req), 0);
        $display("[TB] txn %s op=%h addr=%h misaligned, no bus access", name, op, addr);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0; stall_hold = 1'b0;
        nop_op();
        mem_aluop = 8'hE0; mem_mem_addr = 32'h100; mem_wreg = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset bus_req", 32'(bus_req), 0);
        chk("reset bus_addr", bus_addr, 0);
        chk("reset bus_sel", 32'(bus_sel), 0);
        chk("reset stallreq", 32'(stallreq), 0);
        chk("reset wb_wreg", 32'(wb_wreg), 0);
        $display("[TB] txn reset");
        @(posedge clk); #1;
        rst = 1'b0;
        nop_op();

        // Non-memory pass-through
        mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h55;
        @(negedge clk);
        chk("nonmem wb_wdata", wb_wdata, 32'h55);
        chk("nonmem wb_wreg", 32'(wb_wreg), 1);
        chk("nonmem stallreq", 32'(stallreq), 0);
        $display("[TB] txn nonmem op=25 wb_wdata=%h", wb_wdata);
        // ack with no transfer outstanding must be ignored
        @(posedge clk); #1; bus_ack = 1'b1;
        @(posedge clk); #1; bus_ack = 1'b0;
        @(negedge clk); chk("stray_ack bus_req", 32'(bus_req), 0);
        @(posedge clk); #1;

        run_txn("lb_103", 8'hE0, 32'h103, 32'h0, 32'h123456F0, 2, 0, 4'b0001, 1'b0, 32'h0, 1'b1, 32'hFFFFFFF0);
        run_txn("sh_202", 8'hE9, 32'h202, 32'hABCD1234, 32'h0, 1, 0, 4'b0011, 1'b1, 32'h12341234, 1'b0, 32'h0);
        run_txn("lhu_10", 8'hE5, 32'h10, 32'h0, 32'h89AB4321, 1, 2, 4'b1100, 1'b0, 32'h0, 1'b1, 32'h000089AB);
        run_txn("lb_100", 8'hE0, 32'h100, 32'h0, 32'h7F000000, 1, 0, 4'b1000, 1'b0, 32'h0, 1'b1, 32'h0000007F);
        run_txn("lh_12", 8'hE1, 32'h12, 32'h0, 32'h12348001, 1, 0, 4'b0011, 1'b0, 32'h0, 1'b1, 32'hFFFF8001);
        run_txn("lbu_101", 8'hE4, 32'h101, 32'h0, 32'h12F00000, 1, 1, 4'b0100, 1'b0, 32'h0, 1'b1, 32'h000000F0);
        run_txn("lw_300", 8'hE3, 32'h300, 32'h0, 32'hDEADBEEF, 3, 0, 4'b1111, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
        run_txn("sb_002", 8'hE8, 32'h002, 32'h000000A5, 32'h0, 1, 0, 4'b0010, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0);
        run_txn("sw_044", 8'hEB, 32'h044, 32'hCAFEF00D, 32'h0, 2, 1, 4'b1111, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0);

        run_misaligned("lw_301", 8'hE3, 32'h301);
        run_misaligned("lh_011", 8'hE1, 32'h011);
        run_misaligned("lhu_013", 8'hE5, 32'h013);
        run_misaligned("sh_203", 8'hE9, 32'h203);
        run_misaligned("sw_402", 8'hEB, 32'h402);

        // Reset while a transfer is outstanding; the late ack must be ignored
        mem_aluop = 8'hE3; mem_mem_addr = 32'h400; mem_wd = 5'd2; mem_wreg = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); chk("rstbusy bus_req_before", 32'(bus_req), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nop_op();
        @(negedge clk); chk("rstbusy bus_req_after", 32'(bus_req), 0);
        bus_ack = 1'b1; bus_rdata = 32'h11111111;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("rstbusy bus_req_ack", 32'(bus_req), 0);
        chk("rstbusy stallreq", 32'(stallreq), 0);
        chk("rstbusy wb_wreg", 32'(wb_wreg), 0);
        $display("[TB] txn reset_in_busy bus_req=%0b", bus_req);
        @(posedge clk); #1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
